// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: branch kinds, ARM condition
// codes, the S1 request record and the target-address helper.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_CBZ   = 2'd0,
    BR_CBNZ  = 2'd1,
    BR_BCOND = 2'd2,
    BR_RSVD  = 2'd3
  } br_kind_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Only imm bits [61:0] survive the <<2, so only those are stored.
  typedef struct packed {
    logic [63:0] pc;
    logic [61:0] imm_word;
    br_kind_t    kind;
    logic [3:0]  cond;
    logic [63:0] rt_val;
    logic [3:0]  flags;
    logic        pred_taken;
    logic [63:0] pred_target;
  } br_req_t;

  // Branch target: PC plus word offset, wrapping modulo 2^64.
  function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                input logic [61:0] imm_word);
    return pc + {imm_word, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Issue-side and result-side handshake bundle of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_pc;
  logic [63:0]      in_imm_ext;
  logic [1:0]       in_kind;
  logic [3:0]       in_cond;
  logic [63:0]      in_rt_val;
  logic [3:0]       in_flags;
  logic             in_pred_taken;
  logic [63:0]      in_pred_target;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             out_taken;
  logic [63:0]      out_target;
  logic             out_mispredict;
  logic [63:0]      out_redirect_pc;

  modport master (
    output in_valid, in_pc, in_imm_ext, in_kind, in_cond, in_rt_val,
           in_flags, in_pred_taken, in_pred_target, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_taken, out_target,
           out_mispredict, out_redirect_pc
  );

  modport slave (
    input  in_valid, in_pc, in_imm_ext, in_kind, in_cond, in_rt_val,
           in_flags, in_pred_taken, in_pred_target, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_taken, out_target,
           out_mispredict, out_redirect_pc
  );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch direction: CBZ/CBNZ on Rt, B.cond on NZCV.
module branch_cond_eval
  import branch_pkg::*;
(
  input  br_kind_t    kind,
  input  logic [3:0]  cond,
  input  logic [3:0]  flags,
  input  logic [63:0] rt_val,
  output logic        taken
);
  logic n_s, z_s, c_s, v_s;
  logic cond_s;

  assign n_s = flags[3];
  assign z_s = flags[2];
  assign c_s = flags[1];
  assign v_s = flags[0];

  // Evaluate the ARM condition code against the flags.
  always_comb begin
    cond_s = 1'b0;
    case (cond)
      COND_EQ: cond_s = z_s;
      COND_NE: cond_s = ~z_s;
      COND_CS: cond_s = c_s;
      COND_CC: cond_s = ~c_s;
      COND_MI: cond_s = n_s;
      COND_PL: cond_s = ~n_s;
      COND_VS: cond_s = v_s;
      COND_VC: cond_s = ~v_s;
      COND_HI: cond_s = c_s & ~z_s;
      COND_LS: cond_s = ~(c_s & ~z_s);
      COND_GE: cond_s = (n_s == v_s);
      COND_LT: cond_s = (n_s != v_s);
      COND_GT: cond_s = ~z_s & (n_s == v_s);
      COND_LE: cond_s = ~(~z_s & (n_s == v_s));
      default: cond_s = 1'b1;  // AL and NV both always taken
    endcase
  end

  // Pick the direction source according to the branch kind.
  always_comb begin
    taken = 1'b0;
    case (kind)
      BR_CBZ:   taken = (rt_val == 64'd0);
      BR_CBNZ:  taken = (rt_val != 64'd0);
      BR_BCOND: taken = cond_s;
      default:  taken = 1'b0;  // reserved kind never branches
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolve pipeline: S1 holds the accepted request, S2 holds
// the registered result (direction, target, mispredict, redirect PC).
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input logic clk,
  input logic reset_n,
  input logic flush,
  branch_resolve_unit_if.slave bus
);
  br_req_t          in_req_s;
  br_req_t          s1_req_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic             s1_valid_r;
  logic             s2_valid_r;
  logic             s1_adv_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             taken_s;
  logic             mispredict_s;
  logic [63:0]      target_s;
  logic [63:0]      fallthrough_s;

  logic [TAG_W-1:0] out_tag_r;
  logic             out_taken_r;
  logic [63:0]      out_target_r;
  logic             out_mispredict_r;
  logic [63:0]      out_redirect_pc_r;

  // S1 drains when S2 is free or S2 is being consumed this cycle.
  assign s1_adv_s   = s1_valid_r & (~s2_valid_r | bus.out_ready);
  // Reset and flush both hold off new work; otherwise accept when S1 frees up.
  assign in_ready_s = reset_n & ~flush & (~s1_valid_r | s1_adv_s);
  assign in_fire_s  = bus.in_valid & in_ready_s;

  // Pack the issue-side fields into the S1 request record.
  always_comb begin
    in_req_s             = '0;
    in_req_s.pc          = bus.in_pc;
    in_req_s.imm_word    = bus.in_imm_ext[61:0];
    in_req_s.kind        = br_kind_t'(bus.in_kind);
    in_req_s.cond        = bus.in_cond;
    in_req_s.rt_val      = bus.in_rt_val;
    in_req_s.flags       = bus.in_flags;
    in_req_s.pred_taken  = bus.in_pred_taken;
    in_req_s.pred_target = bus.in_pred_target;
  end

  branch_cond_eval u_cond_eval (
    .kind   (s1_req_r.kind),
    .cond   (s1_req_r.cond),
    .flags  (s1_req_r.flags),
    .rt_val (s1_req_r.rt_val),
    .taken  (taken_s)
  );

  assign target_s      = branch_target(s1_req_r.pc, s1_req_r.imm_word);
  assign fallthrough_s = s1_req_r.pc + 64'd4;

  // Wrong direction, or right direction (taken) to the wrong address.
  assign mispredict_s = (taken_s != s1_req_r.pred_taken) |
                        (taken_s & s1_req_r.pred_taken &
                         (s1_req_r.pred_target != target_s));

  // S1 stage register: capture on accept, empty when passed on or flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_req_r   <= '0;
      s1_tag_r   <= '0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_req_r   <= in_req_s;
      s1_tag_r   <= bus.in_tag;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // S2 result register: load resolved branch, clear on transfer or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r        <= 1'b0;
      out_tag_r         <= '0;
      out_taken_r       <= 1'b0;
      out_target_r      <= 64'd0;
      out_mispredict_r  <= 1'b0;
      out_redirect_pc_r <= 64'd0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r        <= 1'b1;
      out_tag_r         <= s1_tag_r;
      out_taken_r       <= taken_s;
      out_target_r      <= target_s;
      out_mispredict_r  <= mispredict_s;
      out_redirect_pc_r <= taken_s ? target_s : fallthrough_s;
    end else if (bus.out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready        = in_ready_s;
  assign bus.out_valid       = s2_valid_r;
  assign bus.out_tag         = out_tag_r;
  assign bus.out_taken       = out_taken_r;
  assign bus.out_target      = out_target_r;
  assign bus.out_mispredict  = out_mispredict_r;
  assign bus.out_redirect_pc = out_redirect_pc_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table, condition sweep
// against an ARM-style reference, backpressure, flush and async reset.
module tb_branch_resolve_unit;
  logic clk;
  logic reset_n;
  logic flush;
  int   n_checks;
  int   n_fail;

  branch_resolve_unit_if #(.TAG_W(6)) bus ();

  branch_resolve_unit #(.TAG_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [63:0] rt;
    logic [3:0]  flags;
    logic        pt;
    logic [63:0] ptgt;
    logic        exp_taken;
    logic [63:0] exp_target;
    logic        exp_misp;
    logic [63:0] exp_redir;
  } vec_t;

  vec_t tbl[10];

  initial clk = 1'b0;
  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ARM pseudocode form: base condition from cond[3:1], inverted by cond[0]
  // except for 1111.
  function automatic logic ref_taken(input logic [1:0] kind, input logic [3:0] cond,
                                     input logic [3:0] nzcv, input logic [63:0] rt);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    r = 1'b0;
    case (kind)
      2'd0: r = (rt == 64'd0);
      2'd1: r = (rt != 64'd0);
      2'd2: begin
        case (cond[3:1])
          3'b000: r = z;
          3'b001: r = c;
          3'b010: r = n;
          3'b011: r = v;
          3'b100: r = c & ~z;
          3'b101: r = (n == v);
          3'b110: r = ~z & (n == v);
          default: r = 1'b1;
        endcase
        if (cond[0] && cond != 4'hF) r = ~r;
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic present(input vec_t v, input logic [5:0] tag);
    bus.in_valid       = 1'b1;
    bus.in_pc          = v.pc;
    bus.in_imm_ext     = v.imm;
    bus.in_kind        = v.kind;
    bus.in_cond        = v.cond;
    bus.in_rt_val      = v.rt;
    bus.in_flags       = v.flags;
    bus.in_pred_taken  = v.pt;
    bus.in_pred_target = v.ptgt;
    bus.in_tag         = tag;
  endtask

  // Send one branch into an idle pipe (called at a negedge) and capture the result.
  task automatic run_one(input vec_t v, input logic [5:0] tag, output logic acc,
                         output int lat, output logic got_valid, output logic [5:0] got_tag,
                         output logic got_taken, output logic [63:0] got_target,
                         output logic got_misp, output logic [63:0] got_redir);
    bus.out_ready = 1'b1;
    present(v, tag);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_valid  = bus.out_valid;
    got_tag    = bus.out_tag;
    got_taken  = bus.out_taken;
    got_target = bus.out_target;
    got_misp   = bus.out_mispredict;
    got_redir  = bus.out_redirect_pc;
    @(negedge clk);
  endtask

  initial begin
    logic        acc, gv, gt, gm;
    logic [5:0]  gtag;
    logic [63:0] gtgt, grd;
    int          lat;
    vec_t        v;
    logic        et;
    logic [63:0] etgt;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = 64'd0; bus.in_imm_ext = 64'd0; bus.in_kind = 2'd0;
    bus.in_cond = 4'd0; bus.in_rt_val = 64'd0; bus.in_flags = 4'd0; bus.in_pred_taken = 1'b0;
    bus.in_pred_target = 64'd0; bus.in_tag = 6'd0; bus.out_ready = 1'b0;

    //            pc                     imm                    kind  cond   rt      flags  pt    ptgt                 taken target                mis   redirect
    tbl[0] = '{64'h1000,             64'h10,                2'd0, 4'h0, 64'd0, 4'h0, 1'b0, 64'h0,             1'b1, 64'h1040,             1'b1, 64'h1040};
    tbl[1] = '{64'h2000,             64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 4'h0, 64'd5, 4'h0, 1'b1, 64'h1FF0,         1'b1, 64'h1FF0,             1'b0, 64'h1FF0};
    tbl[2] = '{64'h2000,             64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 4'h0, 64'd5, 4'h0, 1'b1, 64'h1FF4,         1'b1, 64'h1FF0,             1'b1, 64'h1FF0};
    tbl[3] = '{64'h3000,             64'h8,                 2'd2, 4'hA, 64'd0, 4'h8, 1'b0, 64'h0,             1'b0, 64'h3020,             1'b0, 64'h3004};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h1,              2'd0, 4'h0, 64'd5, 4'h0, 1'b0, 64'h0,             1'b0, 64'h0,                1'b0, 64'h0};
    tbl[5] = '{64'h6000,             64'h2,                 2'd0, 4'h0, 64'd5, 4'h0, 1'b1, 64'h6008,          1'b0, 64'h6008,             1'b1, 64'h6004};
    tbl[6] = '{64'h7000,             64'h0,                 2'd3, 4'hE, 64'd0, 4'h0, 1'b1, 64'h7000,          1'b0, 64'h7000,             1'b1, 64'h7004};
    tbl[7] = '{64'h4000,             64'h100,               2'd2, 4'hE, 64'd0, 4'h0, 1'b1, 64'h4400,          1'b1, 64'h4400,             1'b0, 64'h4400};
    tbl[8] = '{64'h5000,             64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 4'hF, 64'd0, 4'h0, 1'b0, 64'h0,           1'b1, 64'h4FFC,             1'b1, 64'h4FFC};
    tbl[9] = '{64'h8000,             64'h4,                 2'd1, 4'h0, 64'd0, 4'h0, 1'b0, 64'h0,             1'b0, 64'h8010,             1'b0, 64'h8004};

    // Reset state
    #3;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_out_target", bus.out_target, 64'd0);
    check("rst_out_redirect", bus.out_redirect_pc, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i], 6'(i + 1), acc, lat, gv, gtag, gt, gtgt, gm, grd);
      check($sformatf("v%0d_accept", i), {63'd0, acc}, 64'd1);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("v%0d_valid", i), {63'd0, gv}, 64'd1);
      check($sformatf("v%0d_tag", i), {58'd0, gtag}, 64'(i + 1));
      check($sformatf("v%0d_taken", i), {63'd0, gt}, {63'd0, tbl[i].exp_taken});
      check($sformatf("v%0d_target", i), gtgt, tbl[i].exp_target);
      check($sformatf("v%0d_misp", i), {63'd0, gm}, {63'd0, tbl[i].exp_misp});
      check($sformatf("v%0d_redirect", i), grd, tbl[i].exp_redir);
    end
    check("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);

    // Sweep all condition codes against all flag values
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        v = tbl[3];
        v.pc    = 64'h9000 + 64'(c * 256 + f * 16);
        v.imm   = 64'(c * 16 + f);
        v.cond  = 4'(c);
        v.flags = 4'(f);
        v.pt    = 1'b0;
        et   = ref_taken(2'd2, 4'(c), 4'(f), 64'd0);
        etgt = v.pc + (v.imm << 2);
        run_one(v, 6'(c * 16 + f), acc, lat, gv, gtag, gt, gtgt, gm, grd);
        check($sformatf("sw_c%0d_f%0d_taken", c, f), {63'd0, gt & gv}, {63'd0, et});
        check($sformatf("sw_c%0d_f%0d_misp", c, f), {63'd0, gm}, {63'd0, et});
        check($sformatf("sw_c%0d_f%0d_redir", c, f), grd, et ? etgt : v.pc + 64'd4);
      end
    end

    // Backpressure: two entries fill the pipe, the third is held off
    v = tbl[0];
    bus.out_ready = 1'b0;
    present(v, 6'd11);
    #1 check("bp_ready1", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    present(v, 6'd12);
    #1 check("bp_ready2", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    present(v, 6'd13);
    #1 check("bp_ready3", {63'd0, bus.in_ready}, 64'd0);
    check("bp_valid_a", {63'd0, bus.out_valid}, 64'd1);
    check("bp_tag_a", {58'd0, bus.out_tag}, 64'd11);
    @(negedge clk);
    check("bp_ready3_hold", {63'd0, bus.in_ready}, 64'd0);
    check("bp_tag_stable", {58'd0, bus.out_tag}, 64'd11);
    check("bp_target_stable", bus.out_target, 64'h1040);
    bus.out_ready = 1'b1;
    #1 check("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_tag_b", {58'd0, bus.out_tag}, 64'd12);
    check("bp_valid_b", {63'd0, bus.out_valid}, 64'd1);
    @(negedge clk);
    check("bp_tag_c", {58'd0, bus.out_tag}, 64'd13);
    check("bp_valid_c", {63'd0, bus.out_valid}, 64'd1);
    @(negedge clk);
    check("bp_empty", {63'd0, bus.out_valid}, 64'd0);

    // Flush with S1 and S2 full and a new input offered
    bus.out_ready = 1'b0;
    present(v, 6'd21);
    @(negedge clk);
    present(v, 6'd22);
    @(negedge clk);
    check("fl_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    present(v, 6'd23);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    #1 check("fl_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("fl_quiet%0d", k), {63'd0, bus.out_valid}, 64'd0);
    end

    // Asynchronous reset while stalled
    bus.out_ready = 1'b0;
    present(tbl[1], 6'd31);
    @(negedge clk);
    present(tbl[1], 6'd32);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ar_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("ar_out_target", bus.out_target, 64'd0);
    check("ar_out_tag", {58'd0, bus.out_tag}, 64'd0);
    check("ar_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ar_quiet%0d", k), {63'd0, bus.out_valid}, 64'd0);
    end
    run_one(tbl[0], 6'd40, acc, lat, gv, gtag, gt, gtgt, gm, grd);
    check("ar_recover_tag", {58'd0, gtag}, 64'd40);
    check("ar_recover_target", gtgt, 64'h1040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer of the 64-bit sign-extended imm19 produced by the immediate extender.
- Resolves CBZ/CBNZ/B.cond branches: computes target = PC + (imm<<2), evaluates the condition, compares against the front-end prediction, and emits the taken/mispredict/redirect result.
- Two-stage valid/ready pipeline between issue and the ROB/fetch-redirect logic; supports flush.

Parameters:
- TAG_W, 6, ROB tag width carried with each branch.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  squash all in-flight entries
- in_valid  in  1  branch presented
- in_ready  out  1  unit accepts this cycle
- in_pc  in  64  branch PC
- in_imm_ext  in  64  sign-extended imm19 (word offset)
- in_kind  in  2  0=CBZ, 1=CBNZ, 2=BCOND, 3=reserved
- in_cond  in  4  ARM condition code (BCOND only)
- in_rt_val  in  64  Rt operand (CBZ/CBNZ)
- in_flags  in  4  NZCV, bit3=N
- in_pred_taken  in  1  front-end prediction
- in_pred_target  in  64  predicted target
- in_tag  in  TAG_W  ROB tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_tag  out  TAG_W  tag of result
- out_taken  out  1  resolved direction
- out_target  out  64  PC + (imm_ext<<2)
- out_mispredict  out  1  prediction wrong
- out_redirect_pc  out  64  out_taken ? out_target : PC+4

Behaviour:
- Reset (async, reset_n=0): s1_valid=s2_valid=0; all outputs 0 immediately; in_ready=0 while reset asserted.
- S1 captures inputs on in_valid&&in_ready. S1->S2 computes target = in_pc + {imm_ext[61:0],2'b00} and fallthrough = in_pc + 4, both mod 2^64 (wrap, no overflow flag).
- Condition: CBZ taken iff rt==0; CBNZ iff rt!=0. BCOND: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !GT, AL/NV (1110/1111) always. Reserved kind: taken=0.
- mispredict = (taken != pred_taken) | (taken & pred_taken & pred_target != target).
- All outputs registered from S2. Latency: 2 cycles input-accept to out_valid with no stall; throughput 1/cycle.
- Handshake: s1_adv = s1_valid & (!s2_valid | out_ready); in_ready = !flush & (!s1_valid | s1_adv). Transfer out when out_valid&&out_ready. out_* stable while out_valid&&!out_ready. Order preserved; capacity 2 entries.
- Flush: at the edge, s1_valid=s2_valid=0. An input offered during flush is not accepted (in_ready=0). Flush dominates a simultaneous out_ready; the squashed result is not counted as transferred.
- out_* data fields hold their last value when out_valid=0 (0 after reset).

Decomposition:
- Package branch_pkg: br_kind_t enum (CBZ, CBNZ, BCOND, RSVD); cond-code localparams (COND_EQ..COND_NV); packed struct br_req_t for S1 contents.
- Sub-module branch_cond_eval: combinational (kind, cond, flags, rt_val) -> taken; instantiated once in S1->S2 logic.

Test Plan:
- CBZ: pc=0x1000, imm_ext=0x10, rt=0, pred_taken=0 -> 2 cycles later out_taken=1, target=0x1040, mispredict=1, redirect=0x1040.
- Negative offset CBNZ: pc=0x2000, imm_ext=0xFFFF_FFFF_FFFF_FFFC, rt=5, pred_taken=1, pred_target=0x1FF0 -> taken=1, target=0x1FF0, mispredict=0. Repeat with pred_target=0x1FF4 -> mispredict=1.
- B.cond GE, NZCV=1000, pc=0x3000, pred_taken=0 -> taken=0, mispredict=0, redirect=0x3004. Sweep all 16 conds against all 16 flag values vs a reference model.
- Backpressure: out_ready=0, three back-to-back inputs -> first two accepted, in_ready=0 on the third. Release -> tags emitted in order, one per cycle, third accepted.
- Flush with s1 and s2 valid plus in_valid=1 -> next cycle out_valid=0, nothing emitted, input not accepted.
- Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, imm_ext=1 -> target=0x0; not-taken redirect=0x0. Async reset mid-stall -> out_valid=0 immediately, no output after release.
